imem_loader: RTL
================

Name: imem_loader

Overview:
- Writer side of the instruction memory. Receives a framed program image as a byte stream from the UART receiver and writes it word by word into the RAM-backed instruction store.
- Holds the CPU while a load is in progress, then signals completion so the CPU can restart from address 0.
- Sits between the UART RX byte interface and the instruction RAM write port.

Parameters:
- DEPTH, 256, instruction store size in 32-bit words; the address index is Address[9:2].
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 1000000, maximum idle clocks allowed between bytes inside a frame.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- load_en  input  1  level; when high the loader accepts frames, when low it returns to IDLE.
- rx_data  input  8  received byte.
- rx_valid  input  1  one-cycle strobe; rx_data is valid in that cycle.
- wr_en  output  1  one-cycle write strobe to the instruction RAM.
- wr_addr  output  32  byte address, word aligned: word_index<<2.
- wr_data  output  32  instruction word.
- cpu_hold  output  1  holds the CPU in reset while high.
- done  output  1  load completed successfully; sticky.
- error  output  1  load aborted; sticky.

Behaviour:
- Interface is fixed: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values:
  - state IDLE.
  - wr_en, cpu_hold, done, error all 0.
  - wr_addr and wr_data 0.
  - Byte and word counters 0; timeout counter 0.
- All outputs are registered.
- States: IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERROR.
- IDLE:
  - Requires load_en=1.
  - rx_valid with rx_data==SYNC_BYTE -> LEN_HI.
  - Any other byte is ignored.
  - cpu_hold is 0.
- LEN_HI / LEN_LO: capture a 16-bit word count, big-endian. On the LEN_LO byte:
  - count==0 -> CSUM (with feature) or DONE (without).
  - count>DEPTH -> ERROR.
  - otherwise -> DATA.
- DATA:
  - Bytes are assembled big-endian, first byte to [31:24].
  - In the cycle after the 4th byte's rx_valid: wr_en=1 for exactly one cycle, wr_data=assembled word, wr_addr=word_index<<2. word_index then increments.
  - After the write of word count-1, go to CSUM (with feature) or DONE (without).
- cpu_hold:
  - Rises in the cycle after the sync byte is accepted.
  - Stays 1 through LEN/DATA/CSUM.
  - Is 0 in DONE, ERROR and IDLE.
- DONE: done=1; ERROR: error=1. Both hold until load_en=0, which clears them and returns to IDLE. Bytes arriving in DONE/ERROR are ignored.
- Timeout:
  - Counter clears on every rx_valid and counts only in LEN_HI/LEN_LO/DATA/CSUM.
  - Reaching TIMEOUT_CYCLES-1 -> ERROR.
  - Words already written stay written.
- load_en falling mid-frame -> IDLE next cycle. cpu_hold drops, no further writes, partial word is discarded.
- rx_valid in the same cycle that load_en falls: the byte is ignored.
- Reset mid-frame: all state returns to reset values next cycle, and a pending wr_en is suppressed.
- wr_addr never exceeds (DEPTH-1)<<2; no wrap-around is possible because count is checked against DEPTH.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - After the data, one extra byte is expected: the XOR of the 2 length bytes and all data bytes.
  - Match -> DONE. Mismatch -> ERROR.
  - The CSUM state applies the same timeout rule.
- Undefined: there is no CSUM state; the frame ends after the last data word and the checksum logic is absent.

Test Plan:
- Reset, then load_en=1 and bytes A5,00,01,20,1C,00,00 -> single wr_en pulse, wr_addr=0, wr_data=201C0000; cpu_hold high from the cycle after A5 until done=1.
- Two-word frame A5,00,02 + 08000003 + 0800002E -> writes at addresses 0x0 then 0x4 with the correct data; done=1 and cpu_hold=0 afterward.
- Stray bytes 00,FF before A5 are ignored; a length of 0x0101 (>256) -> error=1 with no wr_en; load_en=0 then clears error.
- Frame stalls after 2 data bytes for TIMEOUT_CYCLES clocks -> error=1, no write for the partial word; a fresh frame after toggling load_en loads correctly.
- load_en dropped after the first word is written -> IDLE next cycle, cpu_hold=0, no further writes; reset asserted mid-word -> all outputs return to 0.
- With IMEM_LOADER_CHECKSUM_EN, frame A5,00,01,20,1C,00,00 + checksum byte 3D -> done=1; the same frame with checksum byte 3C -> error=1 (the word was still written).

Source files
------------

// File: rtl/imem_loader_if.sv
// imem_loader_if: UART RX byte stream into the loader and the instruction RAM write port out of it.
interface imem_loader_if;
   logic [7:0] rx_data;
   logic rx_valid;
   logic wr_en;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;
   modport master (input rx_data, rx_valid, output wr_en, wr_addr, wr_data);
   modport slave (output rx_data, rx_valid, input wr_en, wr_addr, wr_data);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: writes a framed UART program image into instruction RAM while holding the CPU.
// Define IMEM_LOADER_CHECKSUM_EN to expect a trailing XOR checksum byte after the data.
module imem_loader #(
   parameter int DEPTH = 256,
   parameter logic [7:0] SYNC_BYTE = 8'hA5,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input logic clk,
   input logic reset,
   input logic load_en,
   imem_loader_if.master bus,
   output logic cpu_hold,
   output logic done,
   output logic error
);
   localparam int IW = $clog2(DEPTH);
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [15:0] DMAX = 16'(DEPTH);
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
   typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERROR} state_t;
   state_t state;
   state_t tail;
   logic [15:0] len;
   logic [15:0] cnt;
   logic [IW-1:0] idx;
   logic [1:0] nb;
   logic [23:0] acc;
   logic [TW-1:0] tmo;
   logic active;
   logic last;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0] csum;
   assign tail = CSUM;
   always_ff @(posedge clk) begin
      if (reset) csum <= '0;
      else if (load_en && bus.rx_valid) csum <= state == LEN_HI ? bus.rx_data : csum ^ bus.rx_data;
   end
`else
   assign tail = DONE;
`endif
   assign active = state inside {LEN_HI, LEN_LO, DATA, CSUM};
   assign cnt = {len[15:8], bus.rx_data};
   assign last = 16'(idx) == len - 16'd1;
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         len <= '0;
         idx <= '0;
         nb <= '0;
         acc <= '0;
         tmo <= '0;
         bus.wr_en <= 1'b0;
         bus.wr_addr <= '0;
         bus.wr_data <= '0;
         cpu_hold <= 1'b0;
         done <= 1'b0;
         error <= 1'b0;
      end else if (!load_en) begin
         state <= IDLE;
         idx <= '0;
         nb <= '0;
         tmo <= '0;
         bus.wr_en <= 1'b0;
         cpu_hold <= 1'b0;
         done <= 1'b0;
         error <= 1'b0;
      end else begin
         bus.wr_en <= 1'b0;
         tmo <= (active && !bus.rx_valid) ? tmo + 1'b1 : '0;
         if (active && !bus.rx_valid && tmo == TMAX) begin
            state <= ERROR;
            error <= 1'b1;
            cpu_hold <= 1'b0;
         end else if (bus.rx_valid) begin
            case (state)
               IDLE: if (bus.rx_data == SYNC_BYTE) begin
                  state <= LEN_HI;
                  cpu_hold <= 1'b1;
                  idx <= '0;
                  nb <= '0;
               end
               LEN_HI: begin
                  len[15:8] <= bus.rx_data;
                  state <= LEN_LO;
               end
               LEN_LO: begin
                  len[7:0] <= bus.rx_data;
                  if (cnt == '0) begin
                     state <= tail;
                     done <= tail == DONE;
                     cpu_hold <= tail != DONE;
                  end else if (cnt > DMAX) begin
                     state <= ERROR;
                     error <= 1'b1;
                     cpu_hold <= 1'b0;
                  end else state <= DATA;
               end
               DATA: begin
                  acc <= {acc[15:0], bus.rx_data};
                  nb <= nb + 1'b1;
                  if (nb == 2'd3) begin
                     bus.wr_en <= 1'b1;
                     bus.wr_addr <= 32'(idx) << 2;
                     bus.wr_data <= {acc, bus.rx_data};
                     idx <= idx + 1'b1;
                     if (last) begin
                        state <= tail;
                        done <= tail == DONE;
                        cpu_hold <= tail != DONE;
                     end
                  end
               end
`ifdef IMEM_LOADER_CHECKSUM_EN
               CSUM: begin
                  state <= bus.rx_data == csum ? DONE : ERROR;
                  done <= bus.rx_data == csum;
                  error <= bus.rx_data != csum;
                  cpu_hold <= 1'b0;
               end
`endif
               default: ;
            endcase
         end
      end
   end
endmodule
